// File: rtl/seg_scan_pkg.sv
// Shared constants and state encoding for the seven-segment scan controller.
package seg_scan_pkg;

  // Phase of the current digit slot.
  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_ON    = 2'd1,
    S_DIM   = 2'd2
  } scan_state_e;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [7:0]  ANODE_OFF  = 8'hFF;

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex nibble to active-low seven-segment glyph, bit order g..a.
module seg_hex_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Pure lookup of the sixteen hex glyphs.
  always_comb begin
    segments = SEG_BLANK;
    case (nibble)
      4'h0: segments = 7'b1000000;
      4'h1: segments = 7'b1111001;
      4'h2: segments = 7'b0100100;
      4'h3: segments = 7'b0110000;
      4'h4: segments = 7'b0011001;
      4'h5: segments = 7'b0010010;
      4'h6: segments = 7'b0000010;
      4'h7: segments = 7'b1111000;
      4'h8: segments = 7'b0000000;
      4'h9: segments = 7'b0010000;
      4'hA: segments = 7'b0001000;
      4'hB: segments = 7'b0000011;
      4'hC: segments = 7'b1000110;
      4'hD: segments = 7'b0100001;
      4'hE: segments = 7'b0000110;
      4'hF: segments = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Eight-digit multiplexed display scanner with blanking, PWM brightness and
// a frame-synchronous double-buffered update port.
module seg_scan_controller
  import seg_scan_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 12500,
  parameter int unsigned BLANK_TICKS     = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_data,
  input  logic [7:0]  upd_blank,
  input  logic [2:0]  brightness,
  output logic [2:0]  digit_sel,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        frame_start
);

  localparam int unsigned ACTIVE_TICKS = TICKS_PER_DIGIT - BLANK_TICKS;
  localparam int unsigned CNT_W        = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       digit_q, digit_d;
  logic [2:0]       bright_q, bright_d;
  scan_state_e      state_q, state_d;
  logic [7:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_start_q;

  logic [31:0] pend_data_q, pend_data_d;
  logic [7:0]  pend_blank_q, pend_blank_d;
  logic        pend_full_q, pend_full_d;
  logic [31:0] shadow_data_q, shadow_data_d;
  logic [7:0]  shadow_blank_q, shadow_blank_d;

  logic        slot_wrap, frame_wrap, accept;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  int unsigned tick_ext, on_ticks;

  assign upd_ready   = !pend_full_q;
  assign accept      = upd_valid && upd_ready;
  assign digit_sel   = digit_q;
  assign anode       = anode_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

  // Slot counter, digit index and per-slot brightness sample.
  always_comb begin
    slot_wrap  = (tick_q == LAST_TICK);
    frame_wrap = slot_wrap && (digit_q == LAST_DIGIT);
    tick_d     = slot_wrap ? '0 : tick_q + CNT_W'(1);
    digit_d    = slot_wrap ? digit_q + 3'd1 : digit_q;
    bright_d   = slot_wrap ? brightness : bright_q;
  end

  // Pending/shadow buffers: shadow only changes on the frame boundary.
  always_comb begin
    pend_data_d    = pend_data_q;
    pend_blank_d   = pend_blank_q;
    pend_full_d    = pend_full_q;
    shadow_data_d  = shadow_data_q;
    shadow_blank_d = shadow_blank_q;
    if (frame_wrap && pend_full_q) begin
      shadow_data_d  = pend_data_q;
      shadow_blank_d = pend_blank_q;
      pend_full_d    = 1'b0;
    end
    // Accept and promote are mutually exclusive: accept needs pending empty.
    if (accept) begin
      pend_data_d  = upd_data;
      pend_blank_d = upd_blank;
      pend_full_d  = 1'b1;
    end
  end

  // Glyph of the digit that will be shown in the next cycle.
  assign nibble = shadow_data_d[{digit_d, 2'b00} +: 4];

  seg_hex_decoder u_decoder (
    .nibble   (nibble),
    .segments (glyph)
  );

  // Next slot phase and the pin values it implies, so pins move with the state.
  always_comb begin
    state_d  = S_DIM;
    anode_d  = ANODE_OFF;
    seg_d    = SEG_BLANK;
    tick_ext = 32'(tick_d);
    on_ticks = (32'(bright_d) + 32'd1) * ACTIVE_TICKS / 32'd8;
    if (tick_ext < BLANK_TICKS) begin
      state_d = S_BLANK;
    end else if (tick_ext < BLANK_TICKS + on_ticks) begin
      state_d = S_ON;
    end
    if (state_d == S_ON && !shadow_blank_d[digit_d]) begin
      anode_d = ~(8'b1 << digit_d);
      seg_d   = glyph;
    end
  end

  // Scan state register and registered display pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q        <= '0;
      digit_q       <= '0;
      bright_q      <= '0;
      state_q       <= S_BLANK;
      anode_q       <= ANODE_OFF;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      digit_q       <= digit_d;
      bright_q      <= bright_d;
      state_q       <= state_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_wrap;
    end
  end

  // Update buffers; reset drops any pending word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_data_q    <= '0;
      pend_blank_q   <= '0;
      pend_full_q    <= 1'b0;
      shadow_data_q  <= '0;
      shadow_blank_q <= ANODE_OFF;
    end else begin
      pend_data_q    <= pend_data_d;
      pend_blank_q   <= pend_blank_d;
      pend_full_q    <= pend_full_d;
      shadow_data_q  <= shadow_data_d;
      shadow_blank_q <= shadow_blank_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench: scenarios queue cycle-tagged expectations, a monitor
// compares them against the pins on the falling edge.
module tb_seg_scan_controller;

  localparam int T = 20;
  localparam int B = 4;

  localparam int K_ANODE = 0;
  localparam int K_SEG   = 1;
  localparam int K_DIG   = 2;
  localparam int K_FS    = 3;
  localparam int K_RDY   = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_data = '0;
  logic [7:0]  upd_blank = '0;
  logic [2:0]  brightness = 3'd7;
  logic [2:0]  digit_sel;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        frame_start;

  seg_scan_controller #(
    .TICKS_PER_DIGIT (T),
    .BLANK_TICKS     (B)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_data    (upd_data),
    .upd_blank   (upd_blank),
    .brightness  (brightness),
    .digit_sel   (digit_sel),
    .anode       (anode),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: value after n rising edges is n.
  int cyc = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;   // -1: check at the next falling edge regardless of reset
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  string kname [5] = '{"anode", "seg", "digit_sel", "frame_start", "upd_ready"};

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_ANODE: return {24'h0, anode};
      K_SEG:   return {25'h0, seg};
      K_DIG:   return {29'h0, digit_sel};
      K_FS:    return {31'h0, frame_start};
      default: return {31'h0, upd_ready};
    endcase
  endfunction

  // Monitor: pop every expectation due this cycle and compare.
  initial begin : monitor
    logic [31:0] act;
    forever begin
      @(negedge clk);
      for (int i = int'(q.size()) - 1; i >= 0; i--) begin
        if (q[i].cyc < 0 || (reset_n && q[i].cyc <= cyc)) begin
          act = sample(q[i].kind);
          n_cmp++;
          if (q[i].cyc >= 0 && q[i].cyc < cyc) begin
            n_bad++;
            $display("FAIL %s cyc %0d: never sampled (now cyc %0d), required %h",
                     kname[q[i].kind], q[i].cyc, cyc, q[i].val);
          end else if (act !== q[i].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %h, required %h",
                     kname[q[i].kind], q[i].cyc, act, q[i].val);
          end
          q.delete(i);
        end
      end
    end
  end

  task automatic expect_at(input int c, input int kind, input logic [31:0] v);
    q.push_back('{cyc: c, kind: kind, val: v});
  endtask

  // Expected pins for one digit slot, first len ticks.
  task automatic push_slot(input int c0, input int d, input logic [3:0] nib,
                           input logic blanked, input int bright, input int len);
    logic       lit;
    logic [7:0] an;
    for (int t = 0; t < len; t++) begin
      lit = (t >= B) && (t < B + (bright + 1) * 2) && !blanked;
      an  = 8'b1 << d;
      an  = ~an;
      expect_at(c0 + t, K_ANODE, lit ? {24'h0, an} : 32'hFF);
      expect_at(c0 + t, K_SEG, lit ? {25'h0, glyph[nib]} : 32'h7F);
      expect_at(c0 + t, K_DIG, 32'(d));
      expect_at(c0 + t, K_FS, (d == 0 && t == 0 && c0 != 0) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic push_frame(input int c0, input logic [31:0] data, input logic [7:0] blank,
                            input int bright);
    for (int d = 0; d < 8; d++) begin
      push_slot(c0 + T * d, d, data[4*d +: 4], blank[d], bright, T);
    end
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) begin
      n_cmp += q.size();
      n_bad += q.size();
      $display("FAIL drain: %0d expectations still queued, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #2;
    reset_n    = 1'b0;
    upd_valid  = 1'b0;
    upd_data   = '0;
    upd_blank  = '0;
    brightness = 3'd7;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic offer(input logic [31:0] data, input logic [7:0] blank);
    upd_data  = data;
    upd_blank = blank;
    upd_valid = 1'b1;
  endtask

  initial begin
    // Idle after reset: two dark frames, digit stepping, first pulse at 160.
    hold_reset();
    push_frame(0, 32'h0, 8'hFF, 7);
    push_frame(160, 32'h0, 8'hFF, 7);
    expect_at(0, K_RDY, 32'h1);
    release_reset();
    drain();

    // Single update at cycle 10, full brightness, shown in frame 2.
    hold_reset();
    push_frame(0, 32'h0, 8'hFF, 7);
    push_frame(160, 32'h76543210, 8'h00, 7);
    expect_at(10, K_RDY, 32'h1);
    expect_at(11, K_RDY, 32'h0);
    expect_at(159, K_RDY, 32'h0);
    expect_at(160, K_RDY, 32'h1);
    release_reset();
    wait_cyc(10);
    offer(32'h76543210, 8'h00);
    wait_cyc(11);
    upd_valid = 1'b0;
    drain();

    // Minimum brightness; a mid-slot change only affects the next slot.
    hold_reset();
    brightness = 3'd0;
    push_frame(0, 32'h0, 8'hFF, 0);
    push_slot(160, 0, 4'hF, 1'b0, 0, T);
    push_slot(180, 1, 4'hE, 1'b0, 0, T);
    push_slot(200, 2, 4'hD, 1'b0, 7, T);
    push_slot(220, 3, 4'hC, 1'b0, 7, T);
    release_reset();
    offer(32'h89ABCDEF, 8'h00);
    wait_cyc(1);
    upd_valid = 1'b0;
    wait_cyc(185);
    brightness = 3'd7;
    drain();

    // Per-digit blanking of the low four digits.
    hold_reset();
    push_frame(0, 32'h0, 8'hFF, 7);
    push_frame(160, 32'h88888888, 8'h0F, 7);
    release_reset();
    offer(32'h88888888, 8'h0F);
    wait_cyc(1);
    upd_valid = 1'b0;
    drain();

    // Back-to-back words: second is held off until the boundary frees pending.
    hold_reset();
    push_frame(0, 32'h0, 8'hFF, 7);
    push_frame(160, 32'h11111111, 8'h00, 7);
    push_frame(320, 32'h22222222, 8'h00, 7);
    expect_at(0, K_RDY, 32'h1);
    expect_at(1, K_RDY, 32'h0);
    expect_at(159, K_RDY, 32'h0);
    expect_at(160, K_RDY, 32'h1);
    expect_at(161, K_RDY, 32'h0);
    release_reset();
    offer(32'h11111111, 8'h00);
    wait_cyc(1);
    offer(32'h22222222, 8'h00);
    wait_cyc(161);
    upd_valid = 1'b0;
    drain();

    // Asynchronous reset in tick 8 of digit 3 with a word pending.
    hold_reset();
    push_frame(0, 32'h0, 8'hFF, 7);
    push_slot(160, 0, 4'h3, 1'b0, 7, T);
    push_slot(180, 1, 4'h3, 1'b0, 7, T);
    push_slot(200, 2, 4'h3, 1'b0, 7, T);
    push_slot(220, 3, 4'h3, 1'b0, 7, 8);
    expect_at(200, K_RDY, 32'h1);
    expect_at(201, K_RDY, 32'h0);
    release_reset();
    offer(32'h33333333, 8'h00);
    wait_cyc(1);
    upd_valid = 1'b0;
    wait_cyc(200);
    offer(32'h44444444, 8'h00);
    wait_cyc(201);
    upd_valid = 1'b0;
    wait_cyc(227);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    expect_at(-1, K_ANODE, 32'hFF);
    expect_at(-1, K_SEG, 32'h7F);
    expect_at(-1, K_DIG, 32'h0);
    expect_at(-1, K_FS, 32'h0);
    expect_at(-1, K_RDY, 32'h1);
    repeat (2) @(posedge clk);
    drain();
    // Pending word must be gone: nothing lights for two frames.
    push_frame(0, 32'h0, 8'hFF, 7);
    push_frame(160, 32'h0, 8'hFF, 7);
    expect_at(0, K_RDY, 32'h1);
    release_reset();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexed scan scheduler for the 8-digit seven-segment display on the pong board. Generates the per-digit refresh sequence, drives active-low anodes and cathodes with anti-ghosting blanking and PWM brightness, and accepts new score words through a valid/ready port. Updates are applied only at frame boundaries, so a displayed frame never mixes old and new digits. Sits between the game/score logic and the board display pins.

## Interface
Parameters:
- TICKS_PER_DIGIT, 12500, clocks per digit slot (100 MHz gives a 1 kHz frame rate)
- BLANK_TICKS, 500, all-anodes-off clocks at the start of each slot; ACTIVE_TICKS = TICKS_PER_DIGIT-BLANK_TICKS must be a multiple of 8 and ≥8

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- upd_valid  in  1  new display word offered
- upd_ready  out  1  pending buffer empty; equals !pending_full
- upd_data  in  32  digit i = upd_data[4i+3:4i], hex nibble
- upd_blank  in  8  bit i=1 blanks digit i
- brightness  in  3  on-fraction = (brightness+1)/8 of ACTIVE_TICKS
- digit_sel  out  3  current digit index, 0..7
- anode  out  8  active-low digit enables
- seg  out  7  active-low cathodes, seg[6:0]=g..a
- frame_start  out  1  one-cycle pulse in the first cycle of each frame

## Operation
- tick_cnt runs 0..TICKS_PER_DIGIT-1 and then wraps. On the wrap, digit_sel increments, 7→0.
- FSM with states S_BLANK, S_ON, S_DIM:
  - S_BLANK while tick_cnt < BLANK_TICKS.
  - S_ON while tick_cnt < BLANK_TICKS+on_ticks.
  - S_DIM for the rest of the slot.
  - Each slot begins in S_BLANK.
- on_ticks = (bright_q+1)*ACTIVE_TICKS/8. bright_q is brightness sampled at each slot wrap, so brightness never changes mid-slot.
- anode:
  - S_ON and not shadow_blank[digit_sel]: anode = ~(8'b1<<digit_sel).
  - Otherwise: 8'hFF.
- seg:
  - During S_ON: decode of shadow_data nibble for digit_sel. Standard hex glyphs 0-9, A b C d E F; 0→7'b1000000, 1→7'b1111001, 8→7'b0000000.
  - Blanked digit, S_BLANK or S_DIM: 7'h7F.
- Handshake:
  - Transfer when upd_valid && upd_ready. upd_data/upd_blank go to the pending registers and pending_full is set, so upd_ready is low from the next cycle.
  - Frame boundary is tick_cnt==TICKS_PER_DIGIT-1 with digit_sel==7. At that edge, if pending_full: shadow ← pending and pending_full is cleared.
  - An update accepted in the boundary cycle itself goes into pending and displays one frame later.
  - upd_valid while not ready is ignored. No data is dropped once accepted.

## Timing
- Reset values:
  - tick_cnt=0, digit_sel=0, state=S_BLANK, bright_q=0.
  - anode=8'hFF, seg=7'h7F, frame_start=0.
  - shadow_data=0, shadow_blank=8'hFF, pending_full=0, so upd_ready=1.
- anode/seg are registered from next-state, so they change on the same edge that the state enters.
- Digit i first lights BLANK_TICKS cycles after its slot starts. It stays lit for on_ticks cycles, or for none if blanked.
- Accept-to-display latency is at most 8*TICKS_PER_DIGIT+1 cycles. An accepted word first appears in digit 0 of the next frame.
- frame_start is high in the first cycle of digits 0's slot. There is no pulse for the first frame after reset.
- brightness=7 gives S_DIM length 0 (S_ON→S_BLANK directly).
- Asserting reset_n mid-slot returns everything to reset values immediately and drops any pending word.

## Structure
- Package seg_scan_pkg holds:
  - state encoding (S_BLANK/S_ON/S_DIM)
  - SEG_BLANK=7'h7F and ANODE_OFF=8'hFF
  - the NUM_DIGITS=8 constant
- Sub-module seg_hex_decoder: combinational 4-bit nibble → 7-bit active-low segments.
- Everything else lives in the top: counters, FSM, pending/shadow buffers and the handshake.

## Test plan
All scenarios use TICKS_PER_DIGIT=20, BLANK_TICKS=4 (ACTIVE=16).
- Reset release, no update → anode stays 8'hFF and seg 7'h7F for 160 cycles. digit_sel steps 0..7 every 20 cycles. First frame_start at cycle 160.
- Update 32'h76543210, blank 8'h00, brightness 7, pushed at cycle 10 → upd_ready low from cycle 11.
  - Frame 2, digit 0 slot (cycles 160..179): anode 8'hFE during ticks 4..19, seg 7'b1000000.
  - Digit 1: seg 7'b1111001.
  - upd_ready returns high at cycle 160.
- brightness 0 → per slot: 4 cycles blank, 2 cycles lit, 14 cycles dark. A change of brightness mid-slot takes effect only from the next slot.
- upd_blank 8'h0F with all digits 8 → anodes 0..3 never low; digits 4..7 show seg 7'b0000000.
- Second update offered while pending_full → held off. upd_valid held high is accepted the cycle after the boundary clears pending. Both words are displayed in order.
- reset_n pulsed low at tick 8 of digit 3 → outputs are at reset values within the same cycle, pending is discarded, upd_ready=1.
